fp16_mul_arbiter: RTL and testbench
===================================

FP16_MUL_ARBITER -- requirements
Module: fp16_mul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one float16 multiplier.
REQ-002 SHALL have parameter LAT, default 3: multiplier latency from de_in to de_out, in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, NREQ bits: per-requester operand valid.
REQ-006 SHALL have port req_ready, output, NREQ bits: per-requester grant, one-hot or zero.
REQ-007 SHALL have port req_a, input, 16*NREQ bits: operand A, requester i in [16*i+15:16*i].
REQ-008 SHALL have port req_b, input, 16*NREQ bits: operand B, same packing as req_a.
REQ-009 SHALL have port mul_de_in, output, 1 bit: valid strobe to the multiplier.
REQ-010 SHALL have ports mul_a and mul_b, output, 16 bits each: operands to the multiplier.
REQ-011 SHALL have port mul_de_out, input, 1 bit: result valid from the multiplier.
REQ-012 SHALL have port mul_data, input, 16 bits: result from the multiplier.
REQ-013 SHALL have port rsp_valid, output, NREQ bits: one-hot result strobe, with no backpressure.
REQ-014 SHALL have port rsp_data, output, 16 bits: result routed to the strobed requester.
REQ-015 SHALL have port busy, output, 1 bit: high while any accepted operation is in flight.
REQ-016 SHALL have port err, output, 1 bit: sticky tag/strobe mismatch flag.

Function
REQ-017 SHALL assert at most one req_ready bit per cycle, derived combinationally from req_valid and the priority pointer.
REQ-018 SHALL count a transfer when req_valid[i] and req_ready[i] are both high; requesters hold valid and operands until they are granted.
REQ-019 SHALL, in a transfer cycle, drive mul_de_in=1 and place the granted operands on mul_a and mul_b combinationally; otherwise it SHALL drive mul_de_in=0 and mul_a=mul_b=0.
REQ-020 SHALL arbitrate round-robin: search starts at pointer ptr; after a grant to i, ptr <= (i+1) mod NREQ; with no grant, ptr is unchanged.
REQ-021 SHALL keep a LAT-deep tag shift register of {vld, idx} that advances every cycle and loads {transfer, granted index}.
REQ-022 SHALL, in the cycle the tag output stage is valid and mul_de_out=1, drive rsp_valid[idx]=1 and rsp_data=mul_data combinationally; this is cycle T+LAT for a transfer in cycle T.
REQ-023 SHALL hold rsp_valid=0 and rsp_data=0 when there is no result.
REQ-024 SHALL set err=1 on the first cycle that mul_de_out differs from the output-stage vld; err holds until rst, and the result is dropped when the tag is invalid.
REQ-025 SHALL drive busy=1 iff any tag stage vld=1 (registered state only).
REQ-026 SHALL sustain one transfer per cycle under continuous requests (full throughput, no bubbles).
REQ-027 SHALL treat mul_data as opaque; no float16 interpretation.

Reset
REQ-028 SHALL, while rst=1, clear ptr to 0, all tag vld bits to 0, and err to 0; req_ready, mul_de_in, rsp_valid and busy SHALL then read 0.
REQ-029 SHALL drop in-flight operations on rst asserted mid-operation; the multiplier reset is tied to ~rst so neither side strobes afterwards.

Configuration
REQ-030 SHALL, when FP16_ARB_FIXED_PRIO_EN is defined, grant the lowest-index valid requester; ptr is not implemented.
REQ-031 SHALL, when FP16_ARB_FIXED_PRIO_EN is undefined, use round-robin per REQ-020.

Verification
REQ-032 SHALL pass this scenario: req_valid=4'b0100 for 1 cycle (a=0x3C00, b=0x4000) -> req_ready=4'b0100; 3 cycles later rsp_valid=4'b0100, rsp_data=0x4000.
REQ-033 SHALL pass this scenario: req_valid=4'b1111 held 8 cycles after reset (round-robin) -> grant order 0,1,2,3,0,1,2,3; mul_de_in=1 every cycle; rsp_valid follows the same order offset by 3 cycles.
REQ-034 SHALL pass this scenario: req_valid=4'b1010 held 4 cycles, FP16_ARB_FIXED_PRIO_EN defined -> req_ready=4'b0010 every cycle; requester 3 is never granted.
REQ-035 SHALL pass this scenario: mul_de_out forced to 1 with no transfer 3 cycles earlier -> rsp_valid=0 and err=1 from the next cycle, held until rst.
REQ-036 SHALL pass this scenario: rst pulsed 1 cycle with 2 operations in flight -> busy=0, no rsp_valid afterwards, ptr=0 (next grant from requester 0).

Source files
------------

// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency float16 multiplier among NREQ requesters.
// Define FP16_ARB_FIXED_PRIO_EN to use fixed lowest-index-first priority instead.
module fp16_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               mul_de_in,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic               mul_de_out,
  input  logic [15:0]        mul_data,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [15:0]        rsp_data,
  output logic               busy,
  output logic               err
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          gfound;
  logic [IW-1:0] gidx;
  logic          xfer;
  logic [LAT-1:0] tag_vld;
  logic [IW-1:0]  tag_idx [LAT];
  logic           out_vld;
  logic [IW-1:0]  out_idx;
  logic           hit;

`ifdef FP16_ARB_FIXED_PRIO_EN
  // Descending scan: the last match written is the lowest index.
  always_comb begin
    gfound = 1'b0;
    gidx   = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (req_valid[k-1]) begin
        gfound = 1'b1;
        gidx   = IW'(k - 1);
      end
    end
  end
`else
  logic [IW-1:0] ptr;
  int unsigned   j;

  // Descending scan over offsets from ptr: the smallest offset wins.
  always_comb begin
    gfound = 1'b0;
    gidx   = '0;
    j      = 0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      j = (32'(ptr) + k - 1) % NREQ;
      if (req_valid[j]) begin
        gfound = 1'b1;
        gidx   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
    end
  end
`endif

  assign xfer      = gfound & ~rst;
  assign req_ready = xfer ? (NREQ'(1) << gidx) : '0;
  assign mul_de_in = xfer;
  assign mul_a     = xfer ? req_a[16*gidx +: 16] : '0;
  assign mul_b     = xfer ? req_b[16*gidx +: 16] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= xfer;
      tag_idx[0] <= gidx;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  assign out_vld   = tag_vld[LAT-1];
  assign out_idx   = tag_idx[LAT-1];
  // A strobe without a valid tag is dropped; it only raises err.
  assign hit       = out_vld & mul_de_out;
  assign rsp_valid = hit ? (NREQ'(1) << out_idx) : '0;
  assign rsp_data  = hit ? mul_data : '0;
  assign busy      = |tag_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (mul_de_out != out_vld) begin
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Scoreboard bench for fp16_mul_arbiter with a stand-in fixed-latency multiplier.
module tb_fp16_mul_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a = '0;
  logic [16*NREQ-1:0] req_b = '0;
  logic               mul_de_in;
  logic [15:0]        mul_a, mul_b;
  logic               mul_de_out;
  logic [15:0]        mul_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [15:0]        rsp_data;
  logic               busy, err;

  fp16_mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_de_in(mul_de_in), .mul_a(mul_a),
    .mul_b(mul_b), .mul_de_out(mul_de_out), .mul_data(mul_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    return a + b - 16'h3C00;
  endfunction

  // Stand-in multiplier: LAT-cycle pipe, cleared by reset, with a spurious-strobe hook.
  logic        inject = 1'b0;
  logic [LAT-1:0] mv;
  logic [15:0] md [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv <= '0;
      for (int i = 0; i < LAT; i++) md[i] <= '0;
    end else begin
      mv[0] <= mul_de_in;
      md[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) begin
        mv[i] <= mv[i-1];
        md[i] <= md[i-1];
      end
    end
  end
  assign mul_de_out = mv[LAT-1] | inject;
  assign mul_data   = md[LAT-1];

  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int due; int idx; logic [15:0] res;} item_t;
  item_t q[$];
  int    cyc = 0;
  int    m_ptr = 0;
  logic  err_exp = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: reference arbiter plus response scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    int eg;
    int jj;
    logic [NREQ-1:0] er;
    item_t it;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_de_in", 32'(mul_de_in), 0);
      chk("rst_rsp", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      q.delete();
      m_ptr = 0;
      err_exp = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("err", 32'(err), 32'(err_exp));
      if (q.size() != 0 && q[0].due == cyc) begin
        it = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << it.idx);
        chk("rsp_data", 32'(rsp_data), 32'(it.res));
      end else begin
        chk("rsp_idle_v", 32'(rsp_valid), 0);
        chk("rsp_idle_d", 32'(rsp_data), 0);
      end
      eg = -1;
`ifdef FP16_ARB_FIXED_PRIO_EN
      for (int k = NREQ - 1; k >= 0; k--) if (req_valid[k]) eg = k;
`else
      for (int k = NREQ - 1; k >= 0; k--) begin
        jj = (m_ptr + k) % NREQ;
        if (req_valid[jj]) eg = jj;
      end
`endif
      er = (eg >= 0) ? (NREQ'(1) << eg) : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("mul_de_in", 32'(mul_de_in), 32'(eg >= 0));
      if (eg >= 0) begin
        chk("mul_a", 32'(mul_a), 32'(req_a[16*eg +: 16]));
        chk("mul_b", 32'(mul_b), 32'(req_b[16*eg +: 16]));
        it.due = cyc + LAT;
        it.idx = eg;
        it.res = fmul(req_a[16*eg +: 16], req_b[16*eg +: 16]);
        q.push_back(it);
        m_ptr = (eg + 1) % NREQ;
      end else begin
        chk("mul_a_idle", 32'(mul_a), 0);
        chk("mul_b_idle", 32'(mul_b), 0);
      end
    end
  end

  // Requesters hold valid and operands until granted; pct is the chance of a new request.
  task automatic drive(input int n, input int pct);
    logic [NREQ-1:0] g;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i] || !req_valid[i]) begin
          if ($urandom_range(99) < pct) begin
            req_valid[i] = 1'b1;
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
          end else begin
            req_valid[i] = 1'b0;
            req_a[16*i +: 16] = '0;
            req_b[16*i +: 16] = '0;
          end
        end
      end
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(2, 0);
    // Single request from requester 2: 1.0 * 2.0
    req_valid[2] = 1'b1;
    req_a[32 +: 16] = 16'h3C00;
    req_b[32 +: 16] = 16'h4000;
    drive(1, 0);
    drive(LAT + 3, 0);
    // Continuous requests right after reset
    pulse_rst();
    drive(8, 100);
    drive(NREQ + LAT + 2, 0);
    drive(300, 40);
    // Reset with operations in flight
    drive(6, 100);
    pulse_rst();
    drive(12, 100);
    drive(NREQ + LAT + 2, 0);
    chk("drained", 32'(q.size()), 0);
    // Spurious result strobe with nothing in flight
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    err_exp = 1'b1;
    drive(100, 50);
    drive(NREQ + LAT + 2, 0);
    pulse_rst();
    drive(4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", 1);
    $fatal(1);
  end
endmodule
